// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline-control types, constants and strobe helpers
//
// Purpose : common definitions for the pipeline hazard controller.
// Contents: state_e   - sequencer state encoding (RUN / MC)
//           REG_W     - default register-specifier width
//           NOP_INSTR - instruction word a flushed pipeline register holds
//           ctrl_t    - bundle of per-stage enable/flush strobes
//           ctrl_run / ctrl_reset - canonical strobe sets
package cpu_pkg;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_MC  = 1'b1
    } state_e;

    localparam int REG_W = 5;

    // A flushed register holds an all-zero word with its write-enable cleared,
    // so it retires without touching architectural state.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exwb_en;
        logic exwb_flush;
        logic mc_busy;
        logic mc_done;
    } ctrl_t;

    // Free-running pipeline: every stage advances, nothing is squashed.
    function automatic ctrl_t ctrl_run();
        ctrl_t c;
        c            = '0;
        c.pc_en      = 1'b1;
        c.ifid_en    = 1'b1;
        c.idex_en    = 1'b1;
        c.exwb_en    = 1'b1;
        return c;
    endfunction

    // Held in reset: nothing loads, every stage is cleared to NOP.
    function automatic ctrl_t ctrl_reset();
        ctrl_t c;
        c            = '0;
        c.ifid_flush = 1'b1;
        c.idex_flush = 1'b1;
        c.exwb_flush = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// rtl/pipe_hazard_ctrl_hazard_detect.sv - combinational load-use hazard compare
//
// Purpose: flags when the instruction in ID reads a register that the load in
//          EX has not yet produced.
// Ports  : id_rs/id_rt, id_uses_rs/id_uses_rt - ID source operands
//          ex_rd, ex_we, ex_is_load           - EX destination info
//          load_use                           - hazard present (comb)
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_we,
    input  logic             ex_is_load,
    output logic             load_use
);

    logic rs_match;
    logic rt_match;

    assign rs_match = id_uses_rs && (id_rs == ex_rd);
    assign rt_match = id_uses_rt && (id_rt == ex_rd);

    // R0 is hard-wired to zero, so a load targeting it never creates a dependency.
    assign load_use = ex_is_load && ex_we && (ex_rd != '0) && (rs_match || rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline register sequencer with hazard handling
//
// Purpose: drives enable/flush strobes for IF_ID, ID_EX, EX_WB and the PC,
//          handling load-use bubbles, taken-branch squashes and multi-cycle
//          EX operations; counts stalled cycles (saturating).
// Ports  : clk, rst (sync, active-low)
//          id_*  - ID operand info      ex_* - EX instruction info
//          pc_en, ifid_en/flush, idex_en/flush, exwb_en/flush - stage strobes
//          mc_busy, mc_done - multi-cycle status
//          stall_cnt        - cycles with the PC held
module pipe_hazard_ctrl #(
    parameter int MC_LAT = 4,
    parameter int REG_W  = cpu_pkg::REG_W,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_we,
    input  logic             ex_is_load,
    input  logic             ex_branch_taken,
    input  logic             ex_mc_start,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exwb_en,
    output logic             exwb_flush,
    output logic             mc_busy,
    output logic             mc_done,
    output logic [CNT_W-1:0] stall_cnt
);

    import cpu_pkg::*;

    // A one-cycle op needs no extra EX occupancy, so the MC path is disabled.
    localparam logic       MC_EN   = (MC_LAT > 1);
    // The start cycle counts toward the latency and the last MC cycle is mc_cnt==0.
    localparam logic [3:0] MC_INIT = 4'(MC_LAT - 2);

    state_e           state_q, state_d;
    logic [3:0]       mc_cnt_q, mc_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    ctrl_t            ctrl;
    logic             load_use;
    logic             mc_start;

    hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard_detect (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .ex_rd      (ex_rd),
        .ex_we      (ex_we),
        .ex_is_load (ex_is_load),
        .load_use   (load_use)
    );

    assign mc_start = ex_mc_start && MC_EN;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            mc_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mc_cnt_q    <= mc_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mc_cnt_d = mc_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mc_start) begin
                    state_d  = ST_MC;
                    mc_cnt_d = MC_INIT;
                end
            end
            ST_MC: begin
                if (mc_cnt_q != 4'd0) begin
                    mc_cnt_d = mc_cnt_q - 4'd1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d  = ST_RUN;
                mc_cnt_d = '0;
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        if (!ctrl.pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_comb begin
        ctrl = ctrl_run();
        if (!rst) begin
            ctrl = ctrl_reset();
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mc_start) begin
                        // Upstream advances normally; EX_WB waits for the result.
                        ctrl.exwb_en    = 1'b0;
                        ctrl.exwb_flush = 1'b1;
                    end else if (ex_branch_taken) begin
                        // Squashing ID makes any load-use hazard moot.
                        ctrl.ifid_flush = 1'b1;
                        ctrl.idex_flush = 1'b1;
                    end else if (load_use) begin
                        ctrl.pc_en      = 1'b0;
                        ctrl.ifid_en    = 1'b0;
                        ctrl.idex_flush = 1'b1;
                    end
                end
                ST_MC: begin
                    // EX is frozen, so branch/load-use are re-evaluated back in RUN.
                    ctrl.pc_en   = 1'b0;
                    ctrl.ifid_en = 1'b0;
                    ctrl.idex_en = 1'b0;
                    ctrl.mc_busy = 1'b1;
                    if (mc_cnt_q != 4'd0) begin
                        ctrl.exwb_en    = 1'b0;
                        ctrl.exwb_flush = 1'b1;
                    end else begin
                        ctrl.mc_done = 1'b1;
                    end
                end
                default: ctrl = ctrl_reset();
            endcase
        end
    end

    assign pc_en      = ctrl.pc_en;
    assign ifid_en    = ctrl.ifid_en;
    assign ifid_flush = ctrl.ifid_flush;
    assign idex_en    = ctrl.idex_en;
    assign idex_flush = ctrl.idex_flush;
    assign exwb_en    = ctrl.exwb_en;
    assign exwb_flush = ctrl.exwb_flush;
    assign mc_busy    = ctrl.mc_busy;
    assign mc_done    = ctrl.mc_done;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    // Strobe vector order: pc_en ifid_en ifid_flush idex_en idex_flush exwb_en exwb_flush mc_busy mc_done
    localparam logic [8:0] S_RUN    = 9'b110101000;
    localparam logic [8:0] S_RESET  = 9'b001010100;
    localparam logic [8:0] S_LU     = 9'b000111000;
    localparam logic [8:0] S_BR     = 9'b111111000;
    localparam logic [8:0] S_MCST   = 9'b110100100;
    localparam logic [8:0] S_MCMID  = 9'b000000110;
    localparam logic [8:0] S_MCLAST = 9'b000001011;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rs, id_uses_rt, ex_we, ex_is_load, ex_branch_taken, ex_mc_start;

    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exwb_en, exwb_flush, mc_busy, mc_done;
    logic [15:0] stall_cnt;
    logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush, s_exwb_en, s_exwb_flush, s_mc_busy, s_mc_done;
    logic [3:0]  s_stall_cnt;

    logic [8:0]  strobes, s_strobes;
    int          checks;
    int          failures;
    int          exp_cnt;

    assign strobes   = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exwb_en, exwb_flush, mc_busy, mc_done};
    assign s_strobes = {s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush, s_exwb_en, s_exwb_flush, s_mc_busy, s_mc_done};

    pipe_hazard_ctrl #(.MC_LAT(4), .REG_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load),
        .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush),
        .exwb_en(exwb_en), .exwb_flush(exwb_flush),
        .mc_busy(mc_busy), .mc_done(mc_done), .stall_cnt(stall_cnt)
    );

    // Small-counter, single-cycle-latency instance for saturation and MC_LAT==1.
    pipe_hazard_ctrl #(.MC_LAT(1), .REG_W(5), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load),
        .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush),
        .idex_en(s_idex_en), .idex_flush(s_idex_flush),
        .exwb_en(s_exwb_en), .exwb_flush(s_exwb_flush),
        .mc_busy(s_mc_busy), .mc_done(s_mc_done), .stall_cnt(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0;
        ex_rd = '0; ex_we = 0; ex_is_load = 0; ex_branch_taken = 0; ex_mc_start = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        step();
        step();
        checks++;
        if (strobes !== S_RESET) begin
            failures++; $display("FAIL reset_strobes got=%b exp=%b", strobes, S_RESET);
        end
        checks++;
        if (stall_cnt !== 16'd0) begin
            failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (strobes !== S_RUN) begin
            failures++; $display("FAIL reset_release_strobes got=%b exp=%b", strobes, S_RUN);
        end
        step();
        checks++;
        if (stall_cnt !== 16'd0 || strobes !== S_RUN) begin
            failures++; $display("FAIL reset_first_cycle got=%0d/%b exp=0/%b", stall_cnt, strobes, S_RUN);
        end
        exp_cnt = 0;
    endtask

    task automatic test_load_use();
        ex_is_load = 1; ex_we = 1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1;
        #1;
        checks++;
        if (strobes !== S_LU) begin
            failures++; $display("FAIL load_use_rs_strobes got=%b exp=%b", strobes, S_LU);
        end
        step();
        clear_inputs();
        exp_cnt = exp_cnt + 1;
        #1;
        checks++;
        if (stall_cnt !== 16'(exp_cnt) || strobes !== S_RUN) begin
            failures++; $display("FAIL load_use_rs_after got=%0d/%b exp=%0d/%b", stall_cnt, strobes, exp_cnt, S_RUN);
        end
        // rt-side dependency
        ex_is_load = 1; ex_we = 1; ex_rd = 5'd7; id_rt = 5'd7; id_uses_rt = 1; id_rs = 5'd3; id_uses_rs = 1;
        #1;
        checks++;
        if (strobes !== S_LU) begin
            failures++; $display("FAIL load_use_rt_strobes got=%b exp=%b", strobes, S_LU);
        end
        // matching rt that is not actually read: no hazard
        id_uses_rt = 0;
        #1;
        checks++;
        if (strobes !== S_RUN) begin
            failures++; $display("FAIL load_use_unused_rt got=%b exp=%b", strobes, S_RUN);
        end
        // non-load writer: no hazard
        id_uses_rt = 1; ex_is_load = 0;
        #1;
        checks++;
        if (strobes !== S_RUN) begin
            failures++; $display("FAIL load_use_not_load got=%b exp=%b", strobes, S_RUN);
        end
        ex_is_load = 1;
        step();
        exp_cnt = exp_cnt + 1;
        clear_inputs();
        #1;
        checks++;
        if (stall_cnt !== 16'(exp_cnt)) begin
            failures++; $display("FAIL load_use_rt_cnt got=%0d exp=%0d", stall_cnt, exp_cnt);
        end
    endtask

    task automatic test_load_r0();
        ex_is_load = 1; ex_we = 1; ex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1; id_rt = 5'd0; id_uses_rt = 1;
        #1;
        checks++;
        if (strobes !== S_RUN) begin
            failures++; $display("FAIL load_r0_strobes got=%b exp=%b", strobes, S_RUN);
        end
        step();
        clear_inputs();
        checks++;
        if (stall_cnt !== 16'(exp_cnt)) begin
            failures++; $display("FAIL load_r0_cnt got=%0d exp=%0d", stall_cnt, exp_cnt);
        end
    endtask

    task automatic test_branch_load_use();
        ex_is_load = 1; ex_we = 1; ex_rd = 5'd9; id_rs = 5'd9; id_uses_rs = 1; ex_branch_taken = 1;
        #1;
        checks++;
        if (strobes !== S_BR) begin
            failures++; $display("FAIL branch_lu_strobes got=%b exp=%b", strobes, S_BR);
        end
        step();
        clear_inputs();
        checks++;
        if (stall_cnt !== 16'(exp_cnt)) begin
            failures++; $display("FAIL branch_lu_cnt got=%0d exp=%0d", stall_cnt, exp_cnt);
        end
    endtask

    task automatic test_multicycle();
        ex_mc_start = 1;
        #1;
        checks++;
        if (strobes !== S_MCST) begin
            failures++; $display("FAIL mc_start_strobes got=%b exp=%b", strobes, S_MCST);
        end
        checks++;
        if (s_strobes !== S_RUN) begin
            failures++; $display("FAIL mc_lat1_start got=%b exp=%b", s_strobes, S_RUN);
        end
        step();
        ex_mc_start = 0;
        #1;
        checks++;
        if (strobes !== S_MCMID) begin
            failures++; $display("FAIL mc_cycle1 got=%b exp=%b", strobes, S_MCMID);
        end
        checks++;
        if (s_strobes !== S_RUN) begin
            failures++; $display("FAIL mc_lat1_no_busy got=%b exp=%b", s_strobes, S_RUN);
        end
        // a branch during MC must be ignored
        ex_branch_taken = 1;
        step();
        checks++;
        if (strobes !== S_MCMID) begin
            failures++; $display("FAIL mc_cycle2_branch_ignored got=%b exp=%b", strobes, S_MCMID);
        end
        step();
        checks++;
        if (strobes !== S_MCLAST) begin
            failures++; $display("FAIL mc_cycle3_done got=%b exp=%b", strobes, S_MCLAST);
        end
        step();
        exp_cnt = exp_cnt + 3;
        checks++;
        if (strobes !== S_BR) begin
            failures++; $display("FAIL mc_return_branch got=%b exp=%b", strobes, S_BR);
        end
        checks++;
        if (stall_cnt !== 16'(exp_cnt)) begin
            failures++; $display("FAIL mc_stall_cnt got=%0d exp=%0d", stall_cnt, exp_cnt);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_back_to_back();
        // two consecutive load-use bubbles from different registers
        ex_is_load = 1; ex_we = 1; ex_rd = 5'd12; id_rs = 5'd12; id_uses_rs = 1;
        step();
        ex_rd = 5'd13; id_rs = 5'd1; id_rt = 5'd13; id_uses_rt = 1;
        #1;
        checks++;
        if (strobes !== S_LU) begin
            failures++; $display("FAIL b2b_second_lu got=%b exp=%b", strobes, S_LU);
        end
        step();
        clear_inputs();
        exp_cnt = exp_cnt + 2;
        #1;
        checks++;
        if (stall_cnt !== 16'(exp_cnt)) begin
            failures++; $display("FAIL b2b_cnt got=%0d exp=%0d", stall_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_in_mc();
        ex_mc_start = 1;
        step();
        ex_mc_start = 0;
        step();
        rst = 0;
        #1;
        checks++;
        if (strobes !== S_RESET) begin
            failures++; $display("FAIL rst_mc_forced got=%b exp=%b", strobes, S_RESET);
        end
        step();
        rst = 1;
        #1;
        checks++;
        if (strobes !== S_RUN || stall_cnt !== 16'd0) begin
            failures++; $display("FAIL rst_mc_run got=%b/%0d exp=%b/0", strobes, stall_cnt, S_RUN);
        end
        step();
        checks++;
        if (strobes !== S_RUN) begin
            failures++; $display("FAIL rst_mc_no_done got=%b exp=%b", strobes, S_RUN);
        end
        exp_cnt = 0;
    endtask

    task automatic test_saturation();
        ex_is_load = 1; ex_we = 1; ex_rd = 5'd4; id_rs = 5'd4; id_uses_rs = 1;
        repeat (15) step();
        exp_cnt = exp_cnt + 15;
        checks++;
        if (s_stall_cnt !== 4'hF) begin
            failures++; $display("FAIL sat_reach_max got=%0d exp=15", s_stall_cnt);
        end
        repeat (3) step();
        exp_cnt = exp_cnt + 3;
        checks++;
        if (s_stall_cnt !== 4'hF) begin
            failures++; $display("FAIL sat_no_wrap got=%0d exp=15", s_stall_cnt);
        end
        checks++;
        if (stall_cnt !== 16'(exp_cnt)) begin
            failures++; $display("FAIL sat_wide_cnt got=%0d exp=%0d", stall_cnt, exp_cnt);
        end
        clear_inputs();
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_cnt  = 0;
        rst      = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_load_r0();
        test_branch_load_use();
        test_multicycle();
        test_back_to_back();
        test_reset_in_mc();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the pipeline registers (IF_ID, ID_EX, EX_WB) of the pipelined CPU.
- Detects load-use hazards, taken-branch redirects and multi-cycle EX operations.
- Drives per-stage enable and flush strobes so each pipeline register holds, bubbles or advances.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- MC_LAT, 4, cycles a multi-cycle EX op (multiply/divide) occupies EX; legal range 1..15.
- REG_W, 5, register-specifier width.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset (asserted when 0).
- id_rs  in  REG_W  source reg 1 of instruction in ID.
- id_rt  in  REG_W  source reg 2 of instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_rd  in  REG_W  destination reg of instruction in EX.
- ex_we  in  1  EX instruction writes the register file.
- ex_is_load  in  1  EX instruction is a load.
- ex_branch_taken  in  1  branch in EX resolved taken.
- ex_mc_start  in  1  EX holds a multi-cycle op; sampled in RUN only.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF_ID load enable.
- ifid_flush  out  1  IF_ID clear to NOP.
- idex_en  out  1  ID_EX load enable.
- idex_flush  out  1  ID_EX clear to NOP.
- exwb_en  out  1  EX_WB load enable.
- exwb_flush  out  1  EX_WB clear to NOP (WE bit 0).
- mc_busy  out  1  high while in MC state.
- mc_done  out  1  one-cycle pulse on the last MC cycle.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- States: RUN, MC. Registers: state, mc_cnt (4 b), stall_cnt.
- Strobes are combinational from state and inputs. Flush takes precedence over en in the pipeline registers.
- Reset (rst==0 at a clk edge):
  - state=RUN, mc_cnt=0, stall_cnt=0.
  - While rst==0, outputs are forced: all *_en=0, all *_flush=1, mc_busy=0, mc_done=0.
- RUN default: all *_en=1, all *_flush=0.
- load_use = ex_is_load & ex_we & (ex_rd!=0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- Priority in RUN, highest first:
  1. ex_mc_start with MC_LAT>1: enter MC next cycle, mc_cnt<=MC_LAT-2. This cycle is normal advance except EX_WB: exwb_en=0, exwb_flush=1.
  2. ex_branch_taken: ifid_flush=1, idex_flush=1, pc_en=1 (loads target). Load-use is ignored because the ID instruction is squashed.
  3. load_use: pc_en=0, ifid_en=0, idex_flush=1, exwb_en=1. Exactly a 1-cycle bubble.
- MC state:
  - pc_en=ifid_en=idex_en=0, mc_busy=1.
  - mc_cnt!=0: exwb_flush=1, mc_cnt decrements.
  - mc_cnt==0: exwb_en=1, mc_done=1, state<=RUN.
  - ex_branch_taken and load_use are ignored in MC; the EX op is frozen, so the hazard is re-evaluated in RUN.
- Total MC occupancy is MC_LAT cycles including the start cycle. MC_LAT==1: ex_mc_start is ignored and the op behaves as single-cycle.
- stall_cnt increments by 1 on each edge where pc_en==0 and rst==1, saturating at all-ones (no wrap).
- ex_rd==0 never causes a stall (R0 is hard-wired).
- Reset mid-MC: the FSM aborts to RUN next edge; no mc_done pulse.

Decomposition:
- Shared package cpu_pkg: state encoding (RUN=1'b0, MC=1'b1), REG_W, NOP encoding used by the flush logic.
- One natural sub-module: hazard_detect. Pure combinational load_use compare, reusable for later forwarding logic. The FSM and counters stay in the top module.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release with no hazards -> first cycle after release shows all en=1, flush=0, stall_cnt=0.
- Load-use: ex_is_load=1, ex_we=1, ex_rd=5, id_rs=5, id_uses_rs=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1, exwb_en=1; stall_cnt=1.
- Load to R0: same as above but ex_rd=0 -> no stall, all en=1.
- Branch + load-use together: ex_branch_taken=1 with a load_use condition -> ifid_flush=1, idex_flush=1, pc_en=1; stall_cnt unchanged.
- Multi-cycle op, MC_LAT=4: ex_mc_start pulse -> mc_busy high 3 cycles, mc_done on the 3rd, exwb_en=1 only on that cycle; pc_en low 3 cycles; stall_cnt=3.
- Reset in MC: drop rst at the 2nd MC cycle -> next edge state=RUN, no mc_done; also preload stall_cnt near max to check it saturates at 0xFFFF.
